// File: rtl/multicycle_control_unit_pkg.sv
// rtl/multicycle_control_unit_pkg.sv - shared types, opcodes and mux encodings for the multicycle control unit
package multicycle_ctrl_pkg;

  // FSM state encoding; also exported on state_dbg
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // ALU operation class
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  // Writeback / PC result select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate format implied by the opcode; anything unrecognised uses I
  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_sel = IMM_S;
      OP_BRANCH: imm_sel = IMM_B;
      OP_JAL:    imm_sel = IMM_J;
      OP_LUI:    imm_sel = IMM_U;
      default:   imm_sel = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - unified memory port handshake between control unit and memory
interface multicycle_control_unit_if;
  logic mem_req;
  logic mem_we;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// rtl/multicycle_control_unit_mem_wait_timer.sv - per-access memory wait-state counter with expiry flag
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  // A zero timeout still needs a one-bit counter to keep the vector legal
  localparam int W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

  logic [W-1:0] count;

  // Count stalled request cycles; saturate at the limit, restart on each state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (MEM_TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I control FSM with memory handshake and traps
module multicycle_control_unit
  import multicycle_ctrl_pkg::*;
#(
  parameter bit JAL_EN      = 1'b1,
  parameter bit LUI_EN      = 1'b1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [6:0]                       opcode,
  multicycle_control_unit_if.master        mem,
  output logic                             ir_write,
  output logic                             pc_update,
  output logic                             branch,
  output logic                             reg_write,
  output logic [1:0]                       alu_src_a,
  output logic [1:0]                       alu_src_b,
  output logic [1:0]                       alu_op,
  output logic [1:0]                       result_src,
  output logic [2:0]                       imm_src,
  output logic                             illegal,
  output logic                             timeout,
  output logic [3:0]                       state_dbg
);

  state_t state;
  state_t next_state;

  // Ungated strobes; reset masks them below so nothing fires while reset is high
  logic req_raw;
  logic we_raw;
  logic irw_raw;
  logic pcu_raw;
  logic br_raw;
  logic rw_raw;
  logic adr_raw;

  logic set_illegal;
  logic set_timeout;
  logic expired;
  logic wait_expire;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (next_state != state),
    .count_en (req_raw & ~mem.mem_ready),
    .expired  (expired)
  );

  // A ready arriving on the limit cycle wins over the timeout
  assign wait_expire = expired & ~mem.mem_ready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Sticky trap cause flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (set_illegal) illegal <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    next_state  = state;
    req_raw     = 1'b0;
    we_raw      = 1'b0;
    adr_raw     = 1'b0;
    irw_raw     = 1'b0;
    pcu_raw     = 1'b0;
    br_raw      = 1'b0;
    rw_raw      = 1'b0;
    alu_src_a   = SRC_A_PC;
    alu_src_b   = SRC_B_RS2;
    alu_op      = ALU_ADD;
    result_src  = RES_ALUOUT;
    set_illegal = 1'b0;
    set_timeout = 1'b0;

    case (state)
      S_FETCH: begin
        req_raw    = 1'b1;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALURESULT;
        if (mem.mem_ready) begin
          irw_raw    = 1'b1;
          pcu_raw    = 1'b1;
          next_state = S_DECODE;
        end else if (wait_expire) begin
          next_state  = S_TRAP;
          set_timeout = 1'b1;
        end
      end

      S_DECODE: begin
        // Branch target computed speculatively into ALUOut
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BEQ;
          OP_JAL: begin
            if (JAL_EN) begin
              next_state = S_JAL;
            end else begin
              next_state  = S_TRAP;
              set_illegal = 1'b1;
            end
          end
          OP_LUI: begin
            if (LUI_EN) begin
              next_state = S_LUI;
            end else begin
              next_state  = S_TRAP;
              set_illegal = 1'b1;
            end
          end
          default: begin
            next_state  = S_TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        req_raw = 1'b1;
        adr_raw = 1'b1;
        if (mem.mem_ready) begin
          next_state = S_MEMWB;
        end else if (wait_expire) begin
          next_state  = S_TRAP;
          set_timeout = 1'b1;
        end
      end

      S_MEMWB: begin
        result_src = RES_MEMDATA;
        rw_raw     = 1'b1;
        next_state = S_FETCH;
      end

      S_MEMWRITE: begin
        req_raw = 1'b1;
        we_raw  = 1'b1;
        adr_raw = 1'b1;
        if (mem.mem_ready) begin
          next_state = S_FETCH;
        end else if (wait_expire) begin
          next_state  = S_TRAP;
          set_timeout = 1'b1;
        end
      end

      S_EXECR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_RFUNCT;
        next_state = S_ALUWB;
      end

      S_EXECI: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        alu_op     = ALU_IFUNCT;
        next_state = S_ALUWB;
      end

      S_ALUWB: begin
        result_src = RES_ALUOUT;
        rw_raw     = 1'b1;
        next_state = S_FETCH;
      end

      S_BEQ: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_SUB;
        result_src = RES_ALUOUT;
        br_raw     = 1'b1;
        next_state = S_FETCH;
      end

      S_JAL: begin
        // Jump to the target held in ALUOut while oldPC+4 forms the link value
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALUOUT;
        pcu_raw    = 1'b1;
        next_state = S_ALUWB;
      end

      S_LUI: begin
        alu_src_a  = SRC_A_ZERO;
        alu_src_b  = SRC_B_IMM;
        next_state = S_ALUWB;
      end

      S_TRAP: begin
        next_state = S_TRAP;
      end

      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

  assign mem.mem_req = req_raw & ~reset;
  assign mem.mem_we  = we_raw  & ~reset;
  assign mem.adr_src = adr_raw;
  assign ir_write    = irw_raw & ~reset;
  assign pc_update   = pcu_raw & ~reset;
  assign branch      = br_raw  & ~reset;
  assign reg_write   = rw_raw  & ~reset;
  assign imm_src     = imm_sel(opcode);
  assign state_dbg   = state;

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle RV32I control FSM, the successor to the single-cycle opcode decoder: sequences each instruction through fetch, decode, execute, memory and writeback states over a shared ALU and a single unified memory port. Sits between the instruction register (opcode source) and the datapath muxes, register file, PC register and memory interface. Adds memory wait-state handshaking, optional JAL/LUI support, illegal-opcode detection and a memory timeout trap.

## Interface
- `JAL_EN`, 1: enable JAL (1101111); when 0 the opcode is illegal.
- `LUI_EN`, 1: enable LUI (0110111); when 0 the opcode is illegal.
- `MEM_TIMEOUT`, 15: wait cycles allowed per memory access before trapping; 0 disables the timeout.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `opcode`  in  7  instr[6:0] from the instruction register.
- `mem_ready`  in  1  memory acknowledge for the current `mem_req`.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write qualifier for `mem_req`.
- `adr_src`  out  1  0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load the instruction register and oldPC.
- `pc_update`  out  1  unconditional PC write.
- `branch`  out  1  PC write if ALU zero.
- `reg_write`  out  1  register-file write.
- `alu_src_a`  out  2  00 = PC, 01 = oldPC, 10 = rs1, 11 = zero.
- `alu_src_b`  out  2  00 = rs2, 01 = imm, 10 = constant 4.
- `alu_op`  out  2  00 = add, 01 = sub/compare, 10 = R-funct, 11 = I-funct.
- `result_src`  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result.
- `imm_src`  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- `illegal`  out  1  sticky: trap caused by an illegal opcode.
- `timeout`  out  1  sticky: trap caused by a memory timeout.
- `state_dbg`  out  4  current state encoding.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, LUI, TRAP.
- Moore outputs are decoded from the state. Exceptions, which decode combinationally: `imm_src` from `opcode` in every state (I for unknown opcodes), and the FETCH strobes, which are qualified by `mem_ready`. Any output not listed for a state is 0.
- **FETCH:** `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `result_src`=10. When `mem_ready`=1: `ir_write`=1 and `pc_update`=1, then go to DECODE.
- **DECODE:** `alu_src_a`=01, `alu_src_b`=01 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BEQ
  - 1101111 with `JAL_EN` → JAL
  - 0110111 with `LUI_EN` → LUI
  - anything else → TRAP, setting `illegal`.
- **MEMADR:** `alu_src_a`=10, `alu_src_b`=01. Next is MEMREAD for a load, otherwise MEMWRITE.
- **MEMREAD:** `mem_req`=1, `adr_src`=1. Go to MEMWB on `mem_ready`.
- **MEMWB:** `result_src`=01, `reg_write`=1. Next is FETCH.
- **MEMWRITE:** `mem_req`=1, `mem_we`=1, `adr_src`=1. Go to FETCH on `mem_ready`.
- **EXECR:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Next is ALUWB.
- **EXECI:** `alu_src_a`=10, `alu_src_b`=01, `alu_op`=11. Next is ALUWB.
- **ALUWB:** `result_src`=00, `reg_write`=1. Next is FETCH.
- **BEQ:** `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `branch`=1. Next is FETCH.
- **JAL:** `alu_src_a`=01, `alu_src_b`=10, `result_src`=00, `pc_update`=1. Next is ALUWB.
- **LUI:** `alu_src_a`=11, `alu_src_b`=01. Next is ALUWB.
- **TRAP:** all strobes 0. The FSM holds in TRAP until `reset`.
- **Wait counter:**
  - Width is `$clog2(MEM_TIMEOUT+1)`.
  - It clears on every state transition.
  - It increments each cycle that `mem_req`=1 and `mem_ready`=0.
  - When the count equals `MEM_TIMEOUT` and `mem_ready`=0, the next state is TRAP and `timeout` is set.
  - If `mem_ready`=1 arrives in the same cycle the limit is reached, `mem_ready` wins.

## Timing
- Reset (asynchronous): state = FETCH, counter = 0, `illegal` = `timeout` = 0.
- While `reset`=1, `mem_req`, `mem_we`, `ir_write`, `pc_update`, `branch` and `reg_write` are forced to 0. All other outputs take their FETCH values.
- Reset asserted mid-instruction abandons the instruction. No strobe is asserted after the asynchronous assertion.
- Cycles per instruction with zero-wait memory (`mem_ready` tied to 1):
  - load: 5
  - store, R-type, I-type, JAL, LUI: 4
  - BEQ: 3
- Each wait cycle adds 1.
- `opcode` must be stable from DECODE to the end of the instruction. The instruction register changes only on FETCH `ir_write`, which guarantees this.
- `state_dbg` and the sticky flags are registered. All other outputs are combinational from the state, the qualifying inputs and `opcode`.

## Structure
- Package `multicycle_ctrl_pkg` holds:
  - the `state_t` enum;
  - opcode constants (`OP_R`, `OP_I`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`, `OP_JAL`, `OP_LUI`);
  - localparam encodings for `alu_src_a`, `alu_src_b`, `alu_op`, `result_src` and `imm_src`.
- One sub-module, `mem_wait_timer`: the wait counter, parametrised by `MEM_TIMEOUT`, with a clear input and an expiry output.

## Test plan
- **Zero-wait R-type:** reset, `mem_ready`=1, `opcode`=0110011 → states FETCH, DECODE, EXECR, ALUWB, FETCH. `reg_write`=1 only in cycle 4; `alu_op`=10 in cycle 3.
- **Load with wait states:** `opcode`=0000011, `mem_ready` low for 3 cycles in MEMREAD → 8 cycles total. MEMWB shows `result_src`=01.
- **Illegal opcode:** `opcode`=1110011 → TRAP after DECODE. `illegal`=1, all strobes 0 until reset. Repeat with `JAL_EN`=0 and opcode 1101111 → same result.
- **Timeout:** `MEM_TIMEOUT`=4, `mem_ready` held 0 in FETCH → TRAP entered on cycle 5, `timeout`=1.
- **Ready at the limit:** `mem_ready` rises exactly when the count reaches the limit → normal DECODE, `timeout`=0.
- **Asynchronous reset mid-MEMWRITE:** assert `reset` between clock edges → `mem_we` drops immediately. After release: FETCH, flags 0.
